// File: rtl/shared_dmem_responder_if.sv
// shared_dmem_responder_if: per-core request/response bundle between cores and the shared data memory
interface shared_dmem_responder_if #(parameter int NUM_CORES = 2);
  logic [NUM_CORES-1:0] req_valid;
  logic [NUM_CORES-1:0] req_we;
  logic [4*NUM_CORES-1:0] req_mask;
  logic [32*NUM_CORES-1:0] req_addr;
  logic [32*NUM_CORES-1:0] req_wdata;
  logic [NUM_CORES-1:0] req_ready;
  logic [NUM_CORES-1:0] rsp_valid;
  logic [31:0] rsp_rdata;
  logic busy;
  modport master (
    output req_valid, req_we, req_mask, req_addr, req_wdata,
    input req_ready, rsp_valid, rsp_rdata, busy
  );
  modport slave (
    input req_valid, req_we, req_mask, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/shared_dmem_responder.sv
// shared_dmem_responder: round-robin arbitrated, byte-masked shared word memory with wait states
module shared_dmem_responder #(
  parameter int NUM_CORES = 2,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input logic clk,
  input logic rst,
  shared_dmem_responder_if.slave bus
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, ACCESS = 2'd2, RESP = 2'd3;
  logic [1:0] state;
  logic [CW-1:0] last_grant, winner;
  logic any_valid;
  logic [3:0] cnt;
  logic we_q;
  logic [3:0] mask_q;
  logic [AW-1:0] idx_q;
  logic [31:0] wdata_q, rdata_q;
  logic [31:0] mem [DEPTH_WORDS];
  function automatic logic [CW-1:0] rr_idx(input logic [CW-1:0] g, input int k);
    return CW'((int'(g) + k) % NUM_CORES);
  endfunction
  // Scan from farthest to nearest so the core just after last_grant wins.
  always_comb begin
    winner = last_grant;
    any_valid = 1'b0;
    for (int k = NUM_CORES; k >= 1; k--) begin
      if (bus.req_valid[rr_idx(last_grant, k)]) begin
        winner = rr_idx(last_grant, k);
        any_valid = 1'b1;
      end
    end
  end
  assign bus.req_ready = (state == IDLE && any_valid && !rst) ? NUM_CORES'(1) << winner : '0;
  assign bus.rsp_valid = (state == RESP) ? NUM_CORES'(1) << last_grant : '0;
  assign bus.rsp_rdata = (state == RESP) ? rdata_q : '0;
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_grant <= CW'(NUM_CORES - 1);
      cnt <= '0;
      we_q <= 1'b0;
      mask_q <= '0;
      idx_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (any_valid) begin
          we_q <= bus.req_we[winner];
          mask_q <= bus.req_mask[4*winner +: 4];
          idx_q <= bus.req_addr[32*winner+2 +: AW];
          wdata_q <= bus.req_wdata[32*winner +: 32];
          last_grant <= winner;
          cnt <= 4'(WAIT_STATES);
          state <= WAIT_STATES > 0 ? WAIT : ACCESS;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= ACCESS;
        end
        ACCESS: begin
          rdata_q <= mem[idx_q];
          state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // Write is suppressed under reset so an abandoned store never commits.
  always_ff @(posedge clk) begin
    if (!rst && state == ACCESS && we_q)
      for (int b = 0; b < 4; b++)
        if (mask_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
  end
endmodule

// File: tb/tb_shared_dmem_responder.sv
// tb_shared_dmem_responder: directed self-checking bench for the shared data memory responder
module tb_shared_dmem_responder;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  shared_dmem_responder_if #(.NUM_CORES(2)) bus ();
  shared_dmem_responder #(.NUM_CORES(2), .DEPTH_WORDS(1024), .WAIT_STATES(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic rst_pulse();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic issue(input int c, input logic we, input logic [3:0] mask, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic got, output int lat,
                       output logic [1:0] rv, output logic [31:0] rd);
    bus.req_we[c] = we;
    bus.req_mask[4*c +: 4] = mask;
    bus.req_addr[32*c +: 32] = addr;
    bus.req_wdata[32*c +: 32] = wdata;
    bus.req_valid[c] = 1'b1;
    got = 1'b0;
    lat = 0;
    rv = '0;
    rd = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = bus.req_ready[c];
    end
    @(posedge clk);
    #1 bus.req_valid[c] = 1'b0;
    if (got)
      for (int i = 1; i <= 20 && rv == 2'b00; i++) begin
        @(negedge clk);
        if (bus.rsp_valid != 2'b00) begin
          lat = i;
          rv = bus.rsp_valid;
          rd = bus.rsp_rdata;
        end
      end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_pulse();
    @(negedge clk);
    checks++; if (bus.req_ready !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=00", bus.rsp_valid); end
    checks++; if (bus.rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", bus.rsp_rdata); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_single_load();
    logic got; int lat; logic [1:0] rv; logic [31:0] rd;
    issue(0, 1'b1, 4'hF, 32'h14, 32'hDEADBEEF, got, lat, rv, rd);
    issue(0, 1'b0, 4'h0, 32'h14, 32'h0, got, lat, rv, rd);
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL load_ready got=%b exp=1", got); end
    checks++; if (lat != 3) begin failures++; $display("FAIL load_latency got=%0d exp=3", lat); end
    checks++; if (rv !== 2'b01) begin failures++; $display("FAIL load_rsp_valid got=%b exp=01", rv); end
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL load_rdata got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_masked_store();
    logic got; int lat; logic [1:0] rv; logic [31:0] rd;
    issue(1, 1'b1, 4'b0110, 32'h14, 32'h11223344, got, lat, rv, rd);
    checks++; if (rv !== 2'b10) begin failures++; $display("FAIL mstore_rsp_valid got=%b exp=10", rv); end
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL mstore_prewrite got=%h exp=deadbeef", rd); end
    issue(0, 1'b0, 4'h0, 32'h14, 32'h0, got, lat, rv, rd);
    checks++; if (rv !== 2'b01) begin failures++; $display("FAIL mload_rsp_valid got=%b exp=01", rv); end
    checks++; if (rd !== 32'hDE2233EF) begin failures++; $display("FAIL mload_rdata got=%h exp=de2233ef", rd); end
  endtask

  task automatic test_round_robin();
    logic [1:0] g [4];
    logic [1:0] prev;
    int n, nrsp;
    rst_pulse();
    bus.req_we = 2'b00;
    bus.req_addr = {32'h14, 32'h14};
    bus.req_valid = 2'b11;
    n = 0; nrsp = 0; prev = 2'b00;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (bus.rsp_valid != 2'b00) begin
        nrsp++;
        checks++; if (bus.rsp_valid !== prev) begin failures++; $display("FAIL rr_rsp got=%b exp=%b", bus.rsp_valid, prev); end
      end
      if (bus.req_ready != 2'b00) begin
        g[n] = bus.req_ready;
        prev = bus.req_ready;
        n++;
      end
    end
    @(posedge clk);
    #1 bus.req_valid = 2'b00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.rsp_valid != 2'b00) begin
        nrsp++;
        checks++; if (bus.rsp_valid !== prev) begin failures++; $display("FAIL rr_rsp got=%b exp=%b", bus.rsp_valid, prev); end
      end
    end
    checks++; if (n != 4) begin failures++; $display("FAIL rr_grant_count got=%0d exp=4", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (g[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", i, g[i], (i % 2 == 0) ? 2'b01 : 2'b10); end
    end
    checks++; if (nrsp != 4) begin failures++; $display("FAIL rr_rsp_count got=%0d exp=4", nrsp); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_wrap_mask_zero();
    logic got; int lat; logic [1:0] rv; logic [31:0] rd;
    issue(0, 1'b1, 4'hF, 32'h0000_1000, 32'hA5A5A5A5, got, lat, rv, rd);
    issue(1, 1'b0, 4'h0, 32'h0, 32'h0, got, lat, rv, rd);
    checks++; if (rd !== 32'hA5A5A5A5) begin failures++; $display("FAIL wrap_load got=%h exp=a5a5a5a5", rd); end
    issue(0, 1'b1, 4'h0, 32'h0, 32'h0, got, lat, rv, rd);
    checks++; if (rv !== 2'b01) begin failures++; $display("FAIL mask0_rsp got=%b exp=01", rv); end
    issue(1, 1'b0, 4'h0, 32'h0, 32'h0, got, lat, rv, rd);
    checks++; if (rd !== 32'hA5A5A5A5) begin failures++; $display("FAIL mask0_unchanged got=%h exp=a5a5a5a5", rd); end
  endtask

  task automatic test_back_pressure();
    int first, pulses;
    bus.req_we = 2'b00;
    bus.req_addr = {32'h0, 32'h14};
    bus.req_valid = 2'b01;
    @(negedge clk);
    checks++; if (bus.req_ready !== 2'b01) begin failures++; $display("FAIL bp_grant0 got=%b exp=01", bus.req_ready); end
    @(posedge clk);
    #1 bus.req_valid = 2'b10;
    first = -1; pulses = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) begin
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL bp_busy got=%b exp=1", bus.busy); end
      end
      if (bus.req_ready[1]) begin
        pulses++;
        if (first < 0) first = i;
        @(posedge clk);
        #1 bus.req_valid = 2'b00;
      end
    end
    checks++; if (first != 4) begin failures++; $display("FAIL bp_first_ready got=%0d exp=4", first); end
    checks++; if (pulses != 1) begin failures++; $display("FAIL bp_pulses got=%0d exp=1", pulses); end
    bus.req_valid = 2'b00;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_store();
    logic got; int lat; logic [1:0] rv; logic [31:0] rd; logic saw;
    issue(0, 1'b1, 4'hF, 32'h1C, 32'h0BADF00D, got, lat, rv, rd);
    bus.req_we[0] = 1'b1;
    bus.req_mask[3:0] = 4'hF;
    bus.req_addr[31:0] = 32'h1C;
    bus.req_wdata[31:0] = 32'h12345678;
    bus.req_valid[0] = 1'b1;
    @(negedge clk);
    checks++; if (bus.req_ready !== 2'b01) begin failures++; $display("FAIL rms_grant got=%b exp=01", bus.req_ready); end
    @(posedge clk);
    #1 bus.req_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL rms_busy_access got=%b exp=1", bus.busy); end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rms_busy_after got=%b exp=0", bus.busy); end
      end
      if (bus.rsp_valid != 2'b00) saw = 1'b1;
    end
    checks++; if (saw !== 1'b0) begin failures++; $display("FAIL rms_no_rsp got=%b exp=0", saw); end
    @(posedge clk);
    #1;
    issue(1, 1'b0, 4'h0, 32'h1C, 32'h0, got, lat, rv, rd);
    checks++; if (rd !== 32'h0BADF00D) begin failures++; $display("FAIL rms_word_kept got=%h exp=0badf00d", rd); end
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_we = '0;
    bus.req_mask = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    test_reset();
    test_single_load();
    test_masked_store();
    test_round_robin();
    test_wrap_mask_zero();
    test_back_pressure();
    test_reset_mid_store();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/shared_dmem_responder.md
Name: shared_dmem_responder

Overview:
- Memory-side responder for the memory-stage data port.
- Accepts word-addressed, byte-masked load/store requests from up to NUM_CORES cores and arbitrates them round-robin.
- Services one request at a time against an internal word array, with a configurable number of wait states.
- Returns read data to the requesting core, acting as the shared data memory behind every core's mem stage.

Parameters:
- NUM_CORES, 2, number of requesting cores (1..8).
- DEPTH_WORDS, 1024, 32-bit words in the array (power of two).
- WAIT_STATES, 1, extra cycles between accept and data access (0..15).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_CORES  per-core request valid.
- req_we  in  NUM_CORES  per-core write enable (1=store, 0=load).
- req_mask  in  4*NUM_CORES  per-core byte lane mask; core i uses bits [4i+3:4i].
- req_addr  in  32*NUM_CORES  per-core byte address; core i uses bits [32i+31:32i].
- req_wdata  in  32*NUM_CORES  per-core store data, already lane-aligned.
- req_ready  out  NUM_CORES  one-hot accept pulse to the winning core.
- rsp_valid  out  NUM_CORES  one-hot response pulse to the served core.
- rsp_rdata  out  32  response word, valid only while rsp_valid is non-zero.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: synchronous active-high.
  - All outputs are 0 and the FSM is in IDLE.
  - The round-robin pointer last_grant is set to NUM_CORES-1, so core 0 has first priority.
  - Array contents are not cleared.
- Word index: req_addr[log2(DEPTH_WORDS)+1:2]. Upper bits are ignored, so addresses wrap modulo the array size. addr[1:0] is ignored.
- Request rule: a core holds valid, we, mask, addr and wdata stable until it sees req_ready. If a core drops valid before ready, that request is simply not taken.
- IDLE state:
  - If any req_valid is set, the winner is the first set bit scanning from last_grant+1 upward, wrapping.
  - req_ready[winner]=1 combinationally in that cycle (T).
  - At the edge: latch we/mask/addr/wdata, set last_grant=winner, load wait counter=WAIT_STATES.
  - Next state is WAIT if WAIT_STATES>0, else ACCESS.
- WAIT state: decrement the counter each cycle. When it reaches 0, go to ACCESS.
- ACCESS state (one cycle):
  - Read the addressed word into rdata_q (read-first).
  - If we=1, for each lane b with mask[b]=1, write wdata byte b into the array at the edge.
  - Go to RESP.
- RESP state (one cycle):
  - rsp_valid[winner]=1 and rsp_rdata=rdata_q.
  - For stores, rsp_rdata carries the pre-write word.
  - Next state is IDLE. req_ready is 0 in RESP.
- Latency: accept at cycle T, rsp_valid at T+WAIT_STATES+2. Peak throughput is one request per WAIT_STATES+3 cycles.
- Masks:
  - mask=4'b0000 with we=1 leaves the array unchanged but still returns a response.
  - Mask bits are ignored for loads; the full word is always returned.
- req_ready is never asserted outside IDLE. Requests arriving while busy wait, and their valid must stay high.
- Several valids in one cycle: exactly one grant. Fairness: a core waiting while another is granted is granted within NUM_CORES transactions.
- rsp_rdata is held at 0 when no response is pending.
- Reset mid-operation: the transaction is abandoned.
  - A store whose ACCESS edge coincides with rst=1 is not committed.
  - No rsp_valid is issued for the abandoned request.
- NUM_CORES=1: the arbiter degenerates to a pass-through grant.

Test Plan:
- Single load (WAIT_STATES=1, preloaded word 5 = 32'hDEADBEEF). Core 0 loads addr 32'h14 at T → req_ready[0] at T, rsp_valid=2'b01 at T+3, rsp_rdata=32'hDEADBEEF.
- Masked store then load.
  - Core 1 stores addr 32'h14, mask 4'b0110, wdata 32'h11223344 → response rdata 32'hDEADBEEF (pre-write).
  - A subsequent load of addr 32'h14 returns 32'hDE2233EF.
- Round-robin: both cores hold valid continuously with loads.
  - Grants alternate 0,1,0,1.
  - After reset the first grant is core 0.
  - Each rsp_valid bit matches the prior grant.
- Wrap and mask zero (DEPTH_WORDS=1024).
  - Store to addr 32'h0000_1000 with mask 4'hF, wdata 32'hA5A5A5A5 → a load of addr 0 returns 32'hA5A5A5A5.
  - A store with mask 0 leaves the word unchanged.
- Back-pressure: core 1 asserts valid while core 0's request is in WAIT → req_ready[1] stays 0 until IDLE, then pulses exactly once.
- Reset mid-store: assert rst in the ACCESS cycle of a store of 32'h12345678 → no rsp_valid, busy=0 next cycle, word keeps its old value.
